// File: rtl/commu_m_fxm_pkg.sv
// Shared types and constants for the fx register bus master.
package commu_m_fxm_pkg;

  localparam int unsigned FX_AW     = 16;
  localparam int unsigned FX_DW     = 8;
  localparam int unsigned FX_ID_LSB = 8;
  localparam int unsigned FX_ID_MSB = 13;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ISSUE,
    RD_WAIT,
    RD_RESP
  } fxm_state_e;

  // Advance to the next beat address: only the low byte moves (wrapping), the module page is held.
  function automatic logic [FX_AW-1:0] fx_next_addr(input logic [FX_AW-1:0] a);
    return {a[FX_AW-1:FX_ID_MSB+1], a[FX_ID_MSB:FX_ID_LSB],
            a[FX_ID_LSB-1:0] + FX_ID_LSB'(1)};
  endfunction

endpackage

// File: rtl/commu_m_fxm_stat.sv
// Saturating counters of issued fx write and read strobes (FXM_STAT_EN builds only).
module commu_m_fxm_stat (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        wr_strobe,
  input  logic        rd_strobe,
  output logic [15:0] wr_cnt,
  output logic [15:0] rd_cnt
);

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (wr_strobe && (wr_cnt != '1)) wr_cnt <= wr_cnt + 16'd1;
      if (rd_strobe && (rd_cnt != '1)) rd_cnt <= rd_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/commu_m_fxm.sv
// fx register bus single-master initiator: write/read bursts with low-byte address increment.
// Define FXM_STAT_EN to add the stat_wr_cnt/stat_rd_cnt strobe counters.
module commu_m_fxm
  import commu_m_fxm_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic             cmd_vld,
  output logic             cmd_rdy,
  input  logic             cmd_wr,
  input  logic [FX_AW-1:0] cmd_addr,
  input  logic [7:0]       cmd_len,
  input  logic             wd_vld,
  output logic             wd_rdy,
  input  logic [FX_DW-1:0] wd_data,
  output logic             rsp_vld,
  input  logic             rsp_rdy,
  output logic [FX_DW-1:0] rsp_data,
  output logic             rsp_last,
  output logic             busy,
  output logic [FX_AW-1:0] fx_waddr,
  output logic             fx_wr,
  output logic [FX_DW-1:0] fx_data,
  output logic [FX_AW-1:0] fx_raddr,
  output logic             fx_rd,
  input  logic [FX_DW-1:0] fx_q
`ifdef FXM_STAT_EN
  ,
  output logic [15:0]      stat_wr_cnt,
  output logic [15:0]      stat_rd_cnt
`endif
);

  localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

  fxm_state_e       state, state_n;
  logic [FX_AW-1:0] addr, addr_n;
  logic [7:0]       len, len_n, beat, beat_n;
  logic [2:0]       lat, lat_n;
  logic             wr_done, wr_done_n;
  logic             wr_issue, rd_capture;

  always_comb begin
    state_n    = state;
    addr_n     = addr;
    len_n      = len;
    beat_n     = beat;
    lat_n      = lat;
    wr_done_n  = wr_done;
    wr_issue   = 1'b0;
    rd_capture = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_vld && cmd_rdy) begin
          addr_n    = cmd_addr;
          len_n     = cmd_len;
          beat_n    = '0;
          wr_done_n = 1'b0;
          state_n   = cmd_wr ? WR : RD_ISSUE;
        end
      end
      // After the last beat WR lingers one cycle with wd_rdy low so busy covers the final strobe.
      WR: begin
        if (wr_done) begin
          state_n = IDLE;
        end else if (wd_vld) begin
          wr_issue  = 1'b1;
          addr_n    = fx_next_addr(addr);
          beat_n    = beat + 8'd1;
          wr_done_n = (beat == len);
        end
      end
      RD_ISSUE: begin
        lat_n   = '0;
        state_n = RD_WAIT;
      end
      RD_WAIT: begin
        if (lat == LAT_LAST) begin
          rd_capture = 1'b1;
          state_n    = RD_RESP;
        end else begin
          lat_n = lat + 3'd1;
        end
      end
      RD_RESP: begin
        if (rsp_rdy) begin
          if (beat == len) begin
            state_n = IDLE;
          end else begin
            addr_n  = fx_next_addr(addr);
            beat_n  = beat + 8'd1;
            state_n = RD_ISSUE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state    <= IDLE;
      addr     <= '0;
      len      <= '0;
      beat     <= '0;
      lat      <= '0;
      wr_done  <= 1'b0;
      cmd_rdy  <= 1'b0;
      fx_wr    <= 1'b0;
      fx_waddr <= '0;
      fx_data  <= '0;
      fx_rd    <= 1'b0;
      fx_raddr <= '0;
      rsp_data <= '0;
    end else begin
      state   <= state_n;
      addr    <= addr_n;
      len     <= len_n;
      beat    <= beat_n;
      lat     <= lat_n;
      wr_done <= wr_done_n;
      cmd_rdy <= (state_n == IDLE);
      fx_wr   <= wr_issue;
      if (wr_issue) begin
        fx_waddr <= addr;
        fx_data  <= wd_data;
      end
      fx_rd <= (state_n == RD_ISSUE);
      if (state_n == RD_ISSUE) fx_raddr <= addr_n;
      if (rd_capture) rsp_data <= fx_q;
    end
  end

  assign busy     = (state != IDLE);
  assign wd_rdy   = (state == WR) && !wr_done;
  assign rsp_vld  = (state == RD_RESP);
  assign rsp_last = rsp_vld && (beat == len);

`ifdef FXM_STAT_EN
  commu_m_fxm_stat u_stat (
    .clk_sys   (clk_sys),
    .rst       (rst),
    .wr_strobe (fx_wr),
    .rd_strobe (fx_rd),
    .wr_cnt    (stat_wr_cnt),
    .rd_cnt    (stat_rd_cnt)
  );
`endif

endmodule

// File: tb/tb_commu_m_fxm.sv
// Randomized bench for commu_m_fxm against a cycle-level transaction model and a simple slave.
module tb_commu_m_fxm;
  localparam int unsigned RD_LAT = 1;

  logic        clk_sys = 1'b0;
  logic        rst;
  logic        cmd_vld, cmd_rdy, cmd_wr;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        wd_vld, wd_rdy;
  logic [7:0]  wd_data;
  logic        rsp_vld, rsp_rdy, rsp_last, busy;
  logic [7:0]  rsp_data;
  logic [15:0] fx_waddr, fx_raddr;
  logic        fx_wr, fx_rd;
  logic [7:0]  fx_data, fx_q;
`ifdef FXM_STAT_EN
  logic [15:0] stat_wr_cnt, stat_rd_cnt;
`endif

  commu_m_fxm #(.RD_LAT(RD_LAT)) dut (
    .clk_sys  (clk_sys),
    .rst      (rst),
    .cmd_vld  (cmd_vld),
    .cmd_rdy  (cmd_rdy),
    .cmd_wr   (cmd_wr),
    .cmd_addr (cmd_addr),
    .cmd_len  (cmd_len),
    .wd_vld   (wd_vld),
    .wd_rdy   (wd_rdy),
    .wd_data  (wd_data),
    .rsp_vld  (rsp_vld),
    .rsp_rdy  (rsp_rdy),
    .rsp_data (rsp_data),
    .rsp_last (rsp_last),
    .busy     (busy),
    .fx_waddr (fx_waddr),
    .fx_wr    (fx_wr),
    .fx_data  (fx_data),
    .fx_raddr (fx_raddr),
    .fx_rd    (fx_rd),
    .fx_q     (fx_q)
`ifdef FXM_STAT_EN
    ,
    .stat_wr_cnt (stat_wr_cnt),
    .stat_rd_cnt (stat_rd_cnt)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  // Slave: returns the low address byte RD_LAT cycles after the fx_rd cycle, junk otherwise.
  logic [7:0] sl_data [RD_LAT];
  logic       sl_vld  [RD_LAT];
  always @(posedge clk_sys) begin
    sl_data[0] <= fx_raddr[7:0];
    sl_vld[0]  <= fx_rd;
    for (int i = 1; i < int'(RD_LAT); i++) begin
      sl_data[i] <= sl_data[i-1];
      sl_vld[i]  <= sl_vld[i-1];
    end
  end
  assign fx_q = (sl_vld[RD_LAT-1] === 1'b1) ? sl_data[RD_LAT-1] : 8'hEE;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int          due;
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_exp_t;

  wr_exp_t     wq[$];
  int          cyc = 0;
  bit          post_rst = 1'b0;
  bit          act = 1'b0;
  bit          is_wr = 1'b0;
  bit          rsp_pend = 1'b0;
  int          act_start, act_end, len, wbeat, rbeat, exp_rd_cyc, exp_rsp_cyc;
  int          n_wr_exp = 0, n_rd_exp = 0;
  logic [15:0] base;

  function automatic logic [15:0] beat_addr(input logic [15:0] b, input int i);
    logic [7:0] lo;
    lo = b[7:0] + 8'(i);
    return {b[15:8], lo};
  endfunction

  // Transaction model evaluated mid-cycle, when inputs and outputs are both settled.
  always @(negedge clk_sys) begin
    bit eb, ew, er, ev;
    cyc++;
    if (rst) begin
      wq.delete();
      act      = 1'b0;
      rsp_pend = 1'b0;
      post_rst = 1'b1;
      n_wr_exp = 0;
      n_rd_exp = 0;
    end else if (post_rst) begin
      post_rst = 1'b0;
      check_eq("rst_ctrl", 32'({cmd_rdy, wd_rdy, rsp_vld, rsp_last, busy, fx_wr, fx_rd}), 32'd0);
      check_eq("rst_addr", 32'({fx_waddr, fx_raddr}), 32'd0);
      check_eq("rst_data", 32'({fx_data, rsp_data}), 32'd0);
    end else begin
      if (act && cyc >= act_end) act = 1'b0;
      eb = act && (cyc >= act_start);
      check_eq("busy", 32'(busy), 32'(eb));
      check_eq("cmd_rdy", 32'(cmd_rdy), 32'(!eb));

      ew = eb && is_wr && (wbeat <= len);
      check_eq("wd_rdy", 32'(wd_rdy), 32'(ew));

      if (wq.size() > 0 && wq[0].due == cyc) begin
        check_eq("fx_wr", 32'(fx_wr), 32'd1);
        check_eq("fx_waddr", 32'(fx_waddr), 32'(wq[0].addr));
        check_eq("fx_data", 32'(fx_data), 32'(wq[0].data));
        void'(wq.pop_front());
        n_wr_exp++;
      end else begin
        check_eq("fx_wr", 32'(fx_wr), 32'd0);
      end

      er = eb && !is_wr && (cyc == exp_rd_cyc);
      check_eq("fx_rd", 32'(fx_rd), 32'(er));
      if (er) begin
        check_eq("fx_raddr", 32'(fx_raddr), 32'(beat_addr(base, rbeat)));
        exp_rsp_cyc = cyc + int'(RD_LAT) + 1;
        rsp_pend    = 1'b1;
        n_rd_exp++;
      end

      ev = rsp_pend && (cyc >= exp_rsp_cyc);
      check_eq("rsp_vld", 32'(rsp_vld), 32'(ev));
      if (ev) begin
        check_eq("rsp_data", 32'(rsp_data), 32'(beat_addr(base, rbeat) & 16'h00FF));
        check_eq("rsp_last", 32'(rsp_last), 32'(rbeat == len));
        if (rsp_rdy) begin
          rsp_pend = 1'b0;
          if (rbeat == len) act_end = cyc + 1;
          else exp_rd_cyc = cyc + 1;
          rbeat++;
        end
      end

      if (ew && wd_vld) begin
        wq.push_back('{due: cyc + 1, addr: beat_addr(base, wbeat), data: wd_data});
        if (wbeat == len) act_end = cyc + 2;
        wbeat++;
      end

      if (!eb && cmd_vld) begin
        act        = 1'b1;
        act_start  = cyc + 1;
        act_end    = 32'h7FFF_FFFF;
        is_wr      = cmd_wr;
        base       = cmd_addr;
        len        = int'(cmd_len);
        wbeat      = 0;
        rbeat      = 0;
        rsp_pend   = 1'b0;
        exp_rd_cyc = cmd_wr ? -1 : cyc + 1;
      end
    end
  end

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic issue(input bit wr, input logic [15:0] a, input logic [7:0] l);
    int t = 0;
    while (!cmd_rdy && t < 50) begin
      step();
      t++;
    end
    if (!cmd_rdy) check_eq("cmd_rdy_wait", 32'(cmd_rdy), 32'd1);
    cmd_vld  = 1'b1;
    cmd_wr   = wr;
    cmd_addr = a;
    cmd_len  = l;
    step();
    cmd_vld = 1'b0;
  endtask

  // wd_mode: 0 held, 1 random, 2 pattern 1,0,1,1,0,1. rsp_mode: 0 ready, 1 random, 2 five-cycle stall on beat 2.
  task automatic run(input int wd_mode, input int rsp_mode, input int fixed_data);
    int         t = 0, p = 0, nrsp = 0, bp = 5;
    logic [5:0] pat = 6'b101101;
    while (busy && t < 3000) begin
      case (wd_mode)
        0:       wd_vld = 1'b1;
        1:       wd_vld = 1'($urandom_range(0, 1));
        default: wd_vld = (p < 6) ? pat[5-p] : 1'b1;
      endcase
      p++;
      wd_data = (fixed_data >= 0) ? 8'(fixed_data) : 8'($urandom);
      case (rsp_mode)
        0: rsp_rdy = 1'b1;
        1: rsp_rdy = 1'($urandom_range(0, 1));
        default: begin
          if (rsp_vld && nrsp == 1 && bp > 0) begin
            rsp_rdy = 1'b0;
            bp--;
          end else begin
            rsp_rdy = 1'b1;
          end
        end
      endcase
      if (rsp_vld && rsp_rdy) nrsp++;
      cmd_vld  = 1'($urandom_range(0, 1));
      cmd_wr   = 1'($urandom_range(0, 1));
      cmd_addr = 16'($urandom);
      cmd_len  = 8'($urandom);
      step();
      t++;
    end
    check_eq("burst_done", 32'(busy), 32'd0);
    cmd_vld = 1'b0;
    wd_vld  = 1'b0;
    rsp_rdy = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired got running exp finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_vld = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
    wd_vld = 1'b0; wd_data = '0; rsp_rdy = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();

    issue(1'b1, 16'h0581, 8'd0);    run(0, 0, 'h5A);
    issue(1'b0, 16'h05FE, 8'd2);    run(0, 0, -1);
    issue(1'b0, 16'h1234, 8'd3);    run(0, 2, -1);
    issue(1'b1, 16'h22FD, 8'd3);    run(2, 0, -1);

    // Reset while the first read is waiting on the slave.
    issue(1'b0, 16'h0310, 8'd3);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (4) step();

    issue(1'b1, 16'h07A0, 8'hFF);   run(0, 0, -1);
    issue(1'b0, 16'h09FF, 8'd0);    run(1, 1, -1);
    repeat (40) begin
      issue(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom_range(0, 7)));
      run(1, 1, -1);
      repeat ($urandom_range(0, 2)) step();
    end
    repeat (5) step();

    check_eq("wq_empty", 32'(wq.size()), 32'd0);
`ifdef FXM_STAT_EN
    check_eq("stat_wr_cnt", 32'(stat_wr_cnt), 32'(n_wr_exp));
    check_eq("stat_rd_cnt", 32'(stat_rd_cnt), 32'(n_rd_exp));
`endif
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/commu_m_fxm.md
# commu_m_fxm

Single-master initiator for the fx register bus: accepts write/read commands from the host command parser, drives `fx_waddr`/`fx_wr`/`fx_data` and `fx_raddr`/`fx_rd`, and returns captured `fx_q` bytes as a response stream. It sits in `commu_m_top` between the host link parser and the fx bus shared by all module register slaves. It supports bursts of 1–256 bytes with low-byte address auto-increment.

## Interface
- `RD_LAT`, 1: cycles from the `fx_rd` cycle to the cycle in which `fx_q` is valid. Range 1–7.
- `clk_sys` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `cmd_vld` in 1: command valid.
- `cmd_rdy` out 1: command ready. High only in IDLE.
- `cmd_wr` in 1: 1 = write burst, 0 = read burst.
- `cmd_addr` in 16: start address. `[13:8]` selects the module id; `[15:14]` pass through.
- `cmd_len` in 8: beat count minus 1.
- `wd_vld` in 1: write-data byte valid.
- `wd_rdy` out 1: write-data ready. High only in WR.
- `wd_data` in 8: write-data byte.
- `rsp_vld` out 1: read byte valid.
- `rsp_rdy` in 1: response accepted.
- `rsp_data` out 8: read byte.
- `rsp_last` out 1: final beat of the read burst.
- `busy` out 1: state is not IDLE.
- `fx_waddr` out 16, `fx_wr` out 1, `fx_data` out 8: fx write side. All registered.
- `fx_raddr` out 16, `fx_rd` out 1: fx read side. All registered.
- `fx_q` in 8: aggregated slave read data.

## Operation
- States:
  - IDLE: accept a command, then go to WR or RD_ISSUE.
  - WR: one beat per `wd` handshake. Go to IDLE after beat `cmd_len`.
  - RD_ISSUE: 1 cycle, `fx_rd`=1, then RD_WAIT.
  - RD_WAIT: count `RD_LAT`, capture `fx_q`, then RD_RESP.
  - RD_RESP: hold the response until `rsp_rdy`. Return to RD_ISSUE, or to IDLE after the last beat.
- Beat count is `cmd_len`+1. `cmd_len`=8'hFF gives 256 beats.
- Address update per beat:
  - `[7:0]` increments by 1 and wraps 8'hFF→8'h00.
  - `[15:8]` is held constant, so a burst never crosses into another module's page.
- Only one read is outstanding at a time.
- A write beat is issued only on a `wd_vld`&`wd_rdy` cycle. No bubbles are inserted when `wd_vld` is held high.
- Response outputs hold stable while `rsp_vld`&~`rsp_rdy`.
- `rsp_last`=1 only with the final read beat.
- Commands are not accepted while `busy`. No command overlap is possible.
- `fx_wr` and `fx_rd` are never high in the same cycle.
- `fx_waddr`/`fx_raddr`/`fx_data` hold their last issued value when idle.
- Reset values: every output is 0 except `cmd_rdy`, which is 0 in the reset cycle and then 1.
- Reset mid-burst: FSM goes to IDLE, strobes go to 0, and remaining beats and any pending response are discarded.

## Timing
- Command handshake in cycle T: the FSM enters WR or RD_ISSUE in T+1.
- Write beat: `wd` handshake in cycle N gives `fx_wr`=1 in N+1, with `fx_waddr`/`fx_data` for that beat.
  - Earliest first write strobe: T+2.
  - Continuous `wd_vld` gives one write per cycle.
- Read beat:
  - `fx_rd`=1 in T+1, with `fx_raddr`.
  - `fx_q` is sampled at the end of cycle T+1+`RD_LAT`.
  - `rsp_vld`=1 from T+2+`RD_LAT`.
  - With `rsp_rdy` held high, beat spacing is `RD_LAT`+2 cycles.
- After the last write strobe or last response handshake, the FSM is back in IDLE next cycle: `busy`=0 and `cmd_rdy`=1.

## Configuration
- `FXM_STAT_EN` defined:
  - Adds outputs `stat_wr_cnt` [15:0] and `stat_rd_cnt` [15:0].
  - They count issued `fx_wr` and `fx_rd` strobes, saturate at 16'hFFFF, and clear on `rst`.
- `FXM_STAT_EN` undefined: the ports and counters are absent, and all other behaviour is identical.

## Structure
- Package `commu_m_fxm_pkg`:
  - FSM state enum: IDLE, WR, RD_ISSUE, RD_WAIT, RD_RESP.
  - Constants: `FX_AW`=16, `FX_DW`=8, `FX_ID_LSB`=8, `FX_ID_MSB`=13.
- Sub-module `commu_m_fxm_stat`: the saturating counter pair. Instantiated only under `FXM_STAT_EN`.

## Test plan
- Single write `cmd_addr`=16'h0581, `cmd_len`=0, `wd_data`=8'h5A, `wd_vld` held → exactly one `fx_wr` pulse at T+2, `fx_waddr`=16'h0581, `fx_data`=8'h5A; `busy` falls the next cycle.
- Read burst `cmd_addr`=16'h05FE, `cmd_len`=2, `RD_LAT`=1, model slave returns the low address byte → `fx_raddr` sequence 05FE, 05FF, 0500; `rsp_data` FE, FF, 00; `rsp_last` on the third beat only.
- Backpressure: `rsp_rdy`=0 for 5 cycles mid-burst → `rsp_data` stable, no new `fx_rd` issued, burst resumes one cycle after `rsp_rdy`.
- Write burst, `cmd_len`=3, `wd_vld` toggling 1,0,1,1,0,1 → four `fx_wr` pulses, each one cycle after its `wd` handshake; addresses increment by 1.
- `rst` asserted in RD_WAIT → all outputs 0; `cmd_rdy`=1 after release; no `rsp_vld` for the aborted burst.
- `FXM_STAT_EN` build: 256-beat write plus 3 reads → `stat_wr_cnt`=256, `stat_rd_cnt`=3.
